serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/full_adder.sv | 15 +
 rtl/serial_add_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package serial_add_ctrl_pkg;

    // Default operand width and matching bit-counter width (2**CNT_W > WIDTH)
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 5;

    // FSM state encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the serial adder controller.
// Latency: combinational, zero cycles.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused LSB first with a registered carry.
// Latency: start accepted at edge E0 -> done pulses in the cycle after edge E0+WIDTH.
// Backpressure: start ignored (not queued) while busy; accepted again in the done cycle.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic             accept;

    // busy is decoded straight from the state so reset clears it immediately
    assign busy     = (state == S_RUN);
    assign accept   = (state == S_IDLE) && start;
    assign last_bit = (count == CNT_LAST);

    full_adder u_fa (a_sh[0], b_sh[0], carry, fa_sum, fa_cout);

    // Control FSM: IDLE accepts a start, RUN lasts exactly WIDTH cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (accept) begin
            state <= S_RUN;
        end else if (busy && last_bit) begin
            state <= S_IDLE;
        end
    end

    // Operand shifters, running carry, partial result and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            carry <= c_in;
            count <= '0;
        end else if (busy) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            acc   <= {fa_sum, acc[WIDTH-1:1]};
            carry <= fa_cout;
            // Return to zero on the last bit so count never reaches WIDTH
            count <= last_bit ? '0 : count + 1'b1;
        end
    end

    // Result registers update only on the completion edge; done is a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
            done  <= 1'b0;
        end else if (busy && last_bit) begin
            sum   <= {fa_sum, acc[WIDTH-1:1]};
            c_out <= fa_cout;
            done  <= 1'b1;
        end else begin
            done  <= 1'b0;
        end
    end

endmodule
